// File: rtl/rt_lookup_arbiter_if.sv
// Lookup-port bundle between requesters, the routing table port B and the arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif

interface rt_lookup_arbiter_if #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned LOG_REQ = 2,
    parameter int unsigned LOG_CTX = 3,
    parameter int unsigned AW      = `ADDR_WIDTH
);
    logic [N_REQ-1:0]         req;
    logic [N_REQ*LOG_CTX-1:0] req_ccid;
    logic [N_REQ*AW-1:0]      req_dest;
    logic [N_REQ-1:0]         gnt;
    logic [LOG_CTX-1:0]       rt_ccid;
    logic [AW-1:0]            rt_dest;
    logic [8:0]               rt_nexthop;
    logic                     resp_valid;
    logic [LOG_REQ-1:0]       resp_id;
    logic [LOG_CTX-1:0]       resp_ccid;
    logic [8:0]               resp_nexthop;
    logic [15:0]              lookup_count;

    modport master (
        output req, req_ccid, req_dest, rt_nexthop,
        input  gnt, rt_ccid, rt_dest, resp_valid, resp_id, resp_ccid, resp_nexthop,
               lookup_count
    );

    modport slave (
        input  req, req_ccid, req_dest, rt_nexthop,
        output gnt, rt_ccid, rt_dest, resp_valid, resp_id, resp_ccid, resp_nexthop,
               lookup_count
    );
endinterface

// File: rtl/rt_lookup_arbiter.sv
// Round-robin arbiter sharing routing-table lookup port B among N_REQ requesters,
// with a 2-cycle registered response path and a saturating lookup counter.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif

module rt_lookup_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned LOG_REQ = 2,
    parameter int unsigned LOG_CTX = 3,
    parameter int unsigned AW      = `ADDR_WIDTH
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               config_done,
    rt_lookup_arbiter_if.slave bus
);

    logic [LOG_REQ-1:0] rr_ptr_q;
    logic [LOG_CTX-1:0] held_ccid_q;
    logic [AW-1:0]      held_dest_q;
    logic               s1_valid_q;
    logic [LOG_REQ-1:0] s1_id_q;
    logic [LOG_CTX-1:0] s1_ccid_q;
    logic               resp_valid_q;
    logic [LOG_REQ-1:0] resp_id_q;
    logic [LOG_CTX-1:0] resp_ccid_q;
    logic [8:0]         resp_nexthop_q;
    logic [15:0]        count_q;

    logic               grant;
    logic               found_hi;
    logic               found_lo;
    logic [LOG_REQ-1:0] idx_hi;
    logic [LOG_REQ-1:0] idx_lo;
    logic [LOG_REQ-1:0] win;
    logic [LOG_CTX-1:0] win_ccid;
    logic [AW-1:0]      win_dest;
    logic [N_REQ-1:0]   gnt;

    // Lowest set index at/after rr_ptr wins; otherwise wrap to the lowest set index overall.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                if (i >= int'(rr_ptr_q)) begin
                    found_hi = 1'b1;
                    idx_hi   = LOG_REQ'(i);
                end
                found_lo = 1'b1;
                idx_lo   = LOG_REQ'(i);
            end
        end
        win   = found_hi ? idx_hi : idx_lo;
        // Gating with reset keeps gnt and the address bus at zero while reset is held.
        grant = reset && enable && config_done && found_lo;
    end

    // Only the winner's fields reach the mux, so idle requesters' fields never propagate.
    always_comb begin
        win_ccid = '0;
        win_dest = '0;
        gnt      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (LOG_REQ'(i) == win) begin
                win_ccid = bus.req_ccid[i*LOG_CTX +: LOG_CTX];
                win_dest = bus.req_dest[i*AW +: AW];
                gnt[i]   = grant;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr_q       <= '0;
            held_ccid_q    <= '0;
            held_dest_q    <= '0;
            s1_valid_q     <= 1'b0;
            s1_id_q        <= '0;
            s1_ccid_q      <= '0;
            resp_valid_q   <= 1'b0;
            resp_id_q      <= '0;
            resp_ccid_q    <= '0;
            resp_nexthop_q <= '0;
            count_q        <= '0;
        end else begin
            if (grant) begin
                rr_ptr_q    <= (win == LOG_REQ'(N_REQ - 1)) ? '0 : win + LOG_REQ'(1);
                held_ccid_q <= win_ccid;
                held_dest_q <= win_dest;
                s1_id_q     <= win;
                s1_ccid_q   <= win_ccid;
                if (count_q != 16'hFFFF) begin
                    count_q <= count_q + 16'd1;
                end
            end
            s1_valid_q   <= grant;
            // Table output is valid one cycle after the address was sampled.
            resp_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                resp_id_q      <= s1_id_q;
                resp_ccid_q    <= s1_ccid_q;
                resp_nexthop_q <= bus.rt_nexthop;
            end
        end
    end

    assign bus.gnt          = gnt;
    assign bus.rt_ccid      = grant ? win_ccid : held_ccid_q;
    assign bus.rt_dest      = grant ? win_dest : held_dest_q;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_id      = resp_id_q;
    assign bus.resp_ccid    = resp_ccid_q;
    assign bus.resp_nexthop = resp_nexthop_q;
    assign bus.lookup_count = count_q;

endmodule

// File: doc/rt_lookup_arbiter.md
Name: rt_lookup_arbiter

Overview:
- Shares the routing table's lookup port B among N_REQ independent requesters, e.g. per-port input units, using work-conserving round-robin arbitration.
- Drives the table's read address (ccid, dest) and tags each lookup with the requester id.
- Returns the 9-bit next hop to the winning requester through a 2-cycle registered response pipeline.
- Blocks all lookups until table configuration is complete, and counts lookups served.

Parameters:
- N_REQ, 4, number of requesters (2..16, need not be a power of two)
- LOG_REQ, 2, width of requester id; must satisfy 2^LOG_REQ >= N_REQ
- LOG_CTX, 3, context id width; must match the routing table
- AW, `ADDR_WIDTH, destination address width

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- enable  in  1  global enable; no new grants while 0
- config_done  in  1  routing table fully loaded; no grants while 0
- req  in  N_REQ  per-requester request level, held until granted
- req_ccid  in  N_REQ*LOG_CTX  packed context ids, requester i at bits [i*LOG_CTX +: LOG_CTX]
- req_dest  in  N_REQ*AW  packed destinations, requester i at bits [i*AW +: AW]
- gnt  out  N_REQ  one-hot grant pulse, combinational, same cycle as the accepted request
- rt_ccid  out  LOG_CTX  to table ccid_inb
- rt_dest  out  AW  to table dest_inb
- rt_nexthop  in  9  from table nexthop_outb; valid 1 cycle after the address is sampled
- resp_valid  out  1  response strobe, one cycle per lookup
- resp_id  out  LOG_REQ  requester that owns the response
- resp_ccid  out  LOG_CTX  context of the response
- resp_nexthop  out  9  lookup result
- lookup_count  out  16  saturating count of grants issued

Behaviour:
- Grant condition: enable=1 and config_done=1 and req != 0.
- Grant selection: first requester at or after rr_ptr with req set, searching in index order and wrapping modulo N_REQ. gnt is one-hot for that requester and zero otherwise.
- At most one grant per cycle. Throughput is one lookup per cycle.
- rr_ptr register:
  - Reset value 0.
  - On a grant to i, rr_ptr <= (i+1) mod N_REQ. For N_REQ not a power of two, wrap explicitly at N_REQ-1 -> 0.
  - Unchanged when there is no grant.
- Address path:
  - In a grant cycle t, rt_ccid/rt_dest are driven combinationally from the winner's fields.
  - In non-grant cycles they drive the held values of the last grant, stored in registers updated on each grant.
  - Reset value of the held address is 0.
- Pipeline stage 1 (edge ending cycle t): s1_valid <= grant, s1_id <= winner index, s1_ccid <= winner ccid.
- Pipeline stage 2 (edge ending t+1):
  - resp_valid <= s1_valid.
  - When s1_valid=1: resp_id <= s1_id, resp_ccid <= s1_ccid, resp_nexthop <= rt_nexthop.
  - When s1_valid=0, the resp data registers hold their values.
- Timing: resp_valid is high in cycle t+2, for exactly one cycle per grant. Back-to-back grants give back-to-back responses in grant order.
- Enable and config_done low:
  - No new grants.
  - Lookups already in flight still complete, because the table read is unconditional. The arbiter's own s1/resp registers ignore enable.
  - req levels are not consumed.
- Request withdrawal: a requester that deasserts req before being granted is dropped silently. No state is kept per requester.
- lookup_count increments by 1 per grant and saturates at 16'hFFFF.
- Reset values (reset=0, asynchronous): gnt=0, resp_valid=0, resp_id=0, resp_ccid=0, resp_nexthop=0, rt_ccid=0, rt_dest=0, lookup_count=0, rr_ptr=0, s1_valid=0.
- Reset asserted mid-operation discards all in-flight lookups; no response is emitted for them after release.
- Reset release: the first grant is possible in the first cycle with reset=1 and all grant conditions met.
- X-safety: unused req_ccid/req_dest fields of non-granted requesters must not affect outputs.

Test Plan:
- Single request: config_done=1, enable=1, req=4'b0100 for one cycle with ccid 5, dest 8'h3C, table entry {1,5,3C}=9'h1A7.
  -> gnt=4'b0100 in cycle 0; rt_ccid=5, rt_dest=8'h3C in cycle 0; resp_valid=1, resp_id=2, resp_ccid=5, resp_nexthop=9'h1A7 in cycle 2; lookup_count=1.
- Fairness: req=4'b1111 held, with each requester dropping its req after its grant.
  -> grants 0,1,2,3 in consecutive cycles; responses id 0,1,2,3 in cycles 2..5; rr_ptr=0 afterwards.
- Re-arbitration: req=4'b1001 held continuously.
  -> grants alternate 0,3,0,3; no requester is granted twice in a row.
- Gating: config_done=0 with req=4'b0001 for 10 cycles, then config_done=1.
  -> no gnt and no resp_valid during the 10 cycles; gnt in the first cycle config_done=1, resp 2 cycles later.
- Enable drop: grants in cycles 0 and 1, enable=0 from cycle 2.
  -> resp_valid in cycles 2 and 3; no further grants while enable=0.
- Reset and saturation:
  - Assert reset in cycle 1 after a grant in cycle 0 -> no resp_valid ever appears for that grant; all outputs 0 immediately.
  - Separately, preload lookup_count near FFFF via 65540 grants -> it holds 16'hFFFF.
  - Repeat the fairness scenario with N_REQ=3 -> grant order 0,1,2,0 and correct wrap.
